// File: rtl/simple_merger_if.sv
// Handshake bundle between four sources, the merger and one downstream sink.
interface simple_merger_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] din1;
   logic [DATA_WIDTH-1:0] din2;
   logic [DATA_WIDTH-1:0] din3;
   logic                  din_en0;
   logic                  din_en1;
   logic                  din_en2;
   logic                  din_en3;
   logic                  din_rdy0;
   logic                  din_rdy1;
   logic                  din_rdy2;
   logic                  din_rdy3;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_en;
   logic [1:0]            dout_addr;
   logic                  dout_rdy;

   // Environment side: drives sources and downstream ready.
   modport master (
      output din0, din1, din2, din3,
      output din_en0, din_en1, din_en2, din_en3,
      input  din_rdy0, din_rdy1, din_rdy2, din_rdy3,
      input  dout, dout_en, dout_addr,
      output dout_rdy
   );

   // Merger side.
   modport slave (
      input  din0, din1, din2, din3,
      input  din_en0, din_en1, din_en2, din_en3,
      output din_rdy0, din_rdy1, din_rdy2, din_rdy3,
      output dout, dout_en, dout_addr,
      input  dout_rdy
   );
endinterface

// File: rtl/simple_merger.sv
// Four-source round-robin merger: one single-entry buffer per source feeding
// one registered output slot tagged with the source index.
module simple_merger #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic           clk,
   input logic           rst,
   simple_merger_if.slave bus
);
   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned IDX_W   = 2;

   logic [DATA_WIDTH-1:0] din    [NUM_SRC];
   logic [DATA_WIDTH-1:0] data_q [NUM_SRC];
   logic [NUM_SRC-1:0]    en;
   logic [NUM_SRC-1:0]    rdy;
   logic [NUM_SRC-1:0]    acc;
   logic [NUM_SRC-1:0]    full;
   logic [IDX_W-1:0]      ptr;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  gnt_vld;
   logic                  out_free;
   logic                  grant;
   logic [DATA_WIDTH-1:0] dout_q;
   logic [IDX_W-1:0]      dout_addr_q;
   logic                  dout_en_q;

   // Flatten the interface into indexable arrays.
   always_comb begin
      din[0] = bus.din0;
      din[1] = bus.din1;
      din[2] = bus.din2;
      din[3] = bus.din3;
      en     = {bus.din_en3, bus.din_en2, bus.din_en1, bus.din_en0};
   end

   // Ready depends only on buffer state and reset, never on dout_rdy.
   assign rdy          = ~full & {NUM_SRC{~rst}};
   assign acc          = en & rdy;
   assign bus.din_rdy0 = rdy[0];
   assign bus.din_rdy1 = rdy[1];
   assign bus.din_rdy2 = rdy[2];
   assign bus.din_rdy3 = rdy[3];
   assign bus.dout      = dout_q;
   assign bus.dout_addr = dout_addr_q;
   assign bus.dout_en   = dout_en_q;

   // Round-robin search: first full buffer starting at ptr.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = ptr;
      idx     = ptr;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = IDX_W'(ptr + IDX_W'(i));
         if (!gnt_vld && full[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign out_free = ~dout_en_q | bus.dout_rdy;
   assign grant    = out_free & gnt_vld;

   // Buffer payload capture; contents are only meaningful while full is set.
   always_ff @(posedge clk) begin
      for (int unsigned n = 0; n < NUM_SRC; n++) begin
         if (acc[n]) data_q[n] <= din[n];
      end
   end

   // Full flags, output slot and arbitration pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         full        <= '0;
         ptr         <= '0;
         dout_q      <= '0;
         dout_addr_q <= '0;
         dout_en_q   <= 1'b0;
      end else begin
         for (int unsigned n = 0; n < NUM_SRC; n++) begin
            if (grant && gnt_idx == IDX_W'(n)) full[n] <= 1'b0;
            if (acc[n])                        full[n] <= 1'b1;
         end
         if (out_free) begin
            if (gnt_vld) begin
               dout_q      <= data_q[gnt_idx];
               dout_addr_q <= gnt_idx;
               dout_en_q   <= 1'b1;
               ptr         <= IDX_W'(gnt_idx + IDX_W'(1));
            end else begin
               dout_q      <= '0;
               dout_addr_q <= '0;
               dout_en_q   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_simple_merger.sv
// Directed bench for simple_merger with hand-computed expectations.
module tb_simple_merger;
   logic clk;
   logic rst;
   int   vectors;
   int   errors;

   simple_merger_if #(.DATA_WIDTH(32)) bus ();

   simple_merger #(.DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic en, input logic [31:0] data,
                          input logic [1:0] addr);
      chk({tag, "_en"},   32'(bus.dout_en),   32'(en));
      chk({tag, "_data"}, bus.dout,           data);
      chk({tag, "_addr"}, 32'(bus.dout_addr), 32'(addr));
   endtask

   function automatic logic [3:0] rdy_vec();
      return {bus.din_rdy3, bus.din_rdy2, bus.din_rdy1, bus.din_rdy0};
   endfunction

   task automatic srcs_off();
      bus.din_en0 = 1'b0;
      bus.din_en1 = 1'b0;
      bus.din_en2 = 1'b0;
      bus.din_en3 = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      logic acc1;
      logic acc3;
      vectors = 0;
      errors  = 0;
      rst = 1'b1;
      bus.din0 = '0;
      bus.din1 = '0;
      bus.din2 = '0;
      bus.din3 = '0;
      srcs_off();
      bus.dout_rdy = 1'b1;

      // Reset state
      tick();
      tick();
      chk_out("reset", 1'b0, 32'h0, 2'd0);
      chk("reset_rdy_low", 32'(rdy_vec()), 32'h0);
      rst = 1'b0;
      #1;
      chk("rdy_after_reset", 32'(rdy_vec()), 32'hF);

      // Idle output for 10 cycles
      for (int c = 0; c < 10; c++) begin
         tick();
         chk_out("idle", 1'b0, 32'h0, 2'd0);
      end

      // Single source, one word
      bus.din2    = 32'hDEADBEEF;
      bus.din_en2 = 1'b1;
      tick();
      bus.din_en2 = 1'b0;
      chk("single_rdy2_full", 32'(bus.din_rdy2), 32'h0);
      chk_out("single_pre", 1'b0, 32'h0, 2'd0);
      tick();
      chk_out("single", 1'b1, 32'hDEADBEEF, 2'd2);
      chk("single_rdy2_free", 32'(bus.din_rdy2), 32'h1);
      tick();
      chk_out("single_post", 1'b0, 32'h0, 2'd0);

      // All four sources in one cycle, ptr back at 0
      pulse_reset();
      bus.din0 = 32'h10;
      bus.din1 = 32'h11;
      bus.din2 = 32'h12;
      bus.din3 = 32'h13;
      bus.din_en0 = 1'b1;
      bus.din_en1 = 1'b1;
      bus.din_en2 = 1'b1;
      bus.din_en3 = 1'b1;
      tick();
      srcs_off();
      chk("all4_rdy_full", 32'(rdy_vec()), 32'h0);
      tick();
      chk_out("all4_g0", 1'b1, 32'h10, 2'd0);
      tick();
      chk_out("all4_g1", 1'b1, 32'h11, 2'd1);
      tick();
      chk_out("all4_g2", 1'b1, 32'h12, 2'd2);
      tick();
      chk_out("all4_g3", 1'b1, 32'h13, 2'd3);
      tick();
      chk_out("all4_drain", 1'b0, 32'h0, 2'd0);

      // Round robin between continuously valid sources 1 and 3 (ptr wrapped to 0)
      bus.din1 = 32'h100;
      bus.din3 = 32'h300;
      bus.din_en1 = 1'b1;
      bus.din_en3 = 1'b1;
      for (int s = 0; s < 5; s++) begin
         acc1 = bus.din_rdy1;
         acc3 = bus.din_rdy3;
         tick();
         if (acc1) bus.din1 = bus.din1 + 32'h1;
         if (acc3) bus.din3 = bus.din3 + 32'h1;
         case (s)
            0: chk_out("rr_e1", 1'b0, 32'h0,   2'd0);
            1: chk_out("rr_g1", 1'b1, 32'h100, 2'd1);
            2: chk_out("rr_g3", 1'b1, 32'h300, 2'd3);
            3: chk_out("rr_g1b", 1'b1, 32'h101, 2'd1);
            default: chk_out("rr_g3b", 1'b1, 32'h301, 2'd3);
         endcase
      end
      srcs_off();
      tick();
      chk_out("rr_tail", 1'b1, 32'h102, 2'd1);
      tick();
      chk_out("rr_idle", 1'b0, 32'h0, 2'd0);

      // Backpressure with source 1 waiting
      pulse_reset();
      bus.dout_rdy = 1'b0;
      bus.din0 = 32'hA5A5A5A5;
      bus.din1 = 32'h77;
      bus.din_en0 = 1'b1;
      bus.din_en1 = 1'b1;
      tick();
      srcs_off();
      tick();
      chk_out("bp_load", 1'b1, 32'hA5A5A5A5, 2'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_out("bp_hold", 1'b1, 32'hA5A5A5A5, 2'd0);
         chk("bp_rdy1", 32'(bus.din_rdy1), 32'h0);
      end
      bus.dout_rdy = 1'b1;
      tick();
      chk_out("bp_release", 1'b1, 32'h77, 2'd1);
      tick();
      chk_out("bp_drain", 1'b0, 32'h0, 2'd0);

      // Reset mid-operation: 3 buffers full, output slot occupied
      bus.dout_rdy = 1'b0;
      bus.din0 = 32'hC0;
      bus.din1 = 32'hC1;
      bus.din2 = 32'hC2;
      bus.din3 = 32'hC3;
      bus.din_en0 = 1'b1;
      bus.din_en1 = 1'b1;
      bus.din_en2 = 1'b1;
      bus.din_en3 = 1'b1;
      tick();
      srcs_off();
      tick();
      chk("mid_busy_en", 32'(bus.dout_en), 32'h1);
      rst = 1'b1;
      tick();
      chk_out("mid_rst", 1'b0, 32'h0, 2'd0);
      chk("mid_rst_rdy_low", 32'(rdy_vec()), 32'h0);
      rst = 1'b0;
      #1;
      chk("mid_rst_rdy_high", 32'(rdy_vec()), 32'hF);
      bus.dout_rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk_out("mid_no_stale", 1'b0, 32'h0, 2'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
